// File: rtl/seven_segment_scan.sv
// Four-digit multiplexed display scanner with a double-buffered BCD value.
// Optional leading-zero blanking via `define LEADING_ZERO_BLANK_EN.
module seven_segment_scan #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load,
    output logic        pending,
    output logic [3:0]  digit,
    output logic [3:0]  an,
    output logic [1:0]  digit_idx
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   disp_q, disp_d;
    logic          pending_q, pending_d;

    logic tick;
    logic boundary;

    always_comb begin
        tick     = (pcnt_q == PCNT_MAX);
        boundary = tick && (idx_q == 2'd3);

        pcnt_d    = tick ? '0 : pcnt_q + PW'(1);
        idx_d     = tick ? idx_q + 2'd1 : idx_q;
        shadow_d  = load ? data_in : shadow_q;
        disp_d    = disp_q;
        pending_d = pending_q;

        // A load landing on the boundary bypasses the shadow so the new
        // value is shown from digit 0 of the very next frame.
        if (load && boundary) begin
            disp_d    = data_in;
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end else if (boundary && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q    <= '0;
            idx_q     <= 2'd0;
            shadow_q  <= 16'h0000;
            disp_q    <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
        end
    end

    logic [3:0] lit;

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        // Digit i is lit if it or any more-significant nibble is non-zero.
        lit[0] = 1'b1;
        lit[1] = |disp_q[15:4];
        lit[2] = |disp_q[15:8];
        lit[3] = |disp_q[15:12];
`else
        lit = 4'b1111;
`endif
        digit_idx = idx_q;
        pending   = pending_q;
        if (lit[idx_q]) begin
            digit = disp_q[{idx_q, 2'b00} +: 4];
            an    = ~(4'b0001 << idx_q);
        end else begin
            digit = 4'h0;
            an    = 4'b1111;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Randomized self-checking bench for seven_segment_scan against a
// cycle-count based reference model.
module tb_seven_segment_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        load;
    logic        pending;
    logic [3:0]  digit;
    logic [3:0]  an;
    logic [1:0]  digit_idx;

    int compared;
    int mismatched;

    // reference model state: cycles since reset plus buffered values
    int          t;
    logic [15:0] m_shadow;
    logic [15:0] m_disp;
    logic        m_pend;

    seven_segment_scan #(.REFRESH_DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .load     (load),
        .pending  (pending),
        .digit    (digit),
        .an       (an),
        .digit_idx(digit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] model_out();
        int         i;
        logic [3:0] d;
        logic [3:0] a;
        i = (t / DIV) % 4;
        d = 4'((m_disp >> (4 * i)) & 16'h000f);
        a = ~(4'b0001 << i);
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && (m_disp >> (4 * i)) == 16'h0000) begin
            a = 4'b1111;
            d = 4'h0;
        end
`endif
        return {m_pend, 2'(i), a, d};
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] dv);
        logic bnd;
        rst     = r;
        load    = l;
        data_in = dv;
        @(posedge clk);
        if (r) begin
            t        = 0;
            m_shadow = 16'h0000;
            m_disp   = 16'h0000;
            m_pend   = 1'b0;
        end else begin
            bnd = ((t % FRAME) == FRAME - 1);
            if (l) m_shadow = dv;
            if (l && bnd) begin
                m_disp = dv;
                m_pend = 1'b0;
            end else if (l) begin
                m_pend = 1'b1;
            end else if (bnd && m_pend) begin
                m_disp = m_shadow;
                m_pend = 1'b0;
            end
            t++;
        end
        #1;
        rst  = 1'b0;
        load = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'hffff);
        compared++;
        if ({pending, digit_idx, an, digit} !== {1'b0, 2'd0, 4'b1110, 4'h0}) begin
            mismatched++;
            $display("FAIL reset: got %b expected %b", {pending, digit_idx, an, digit},
                     {1'b0, 2'd0, 4'b1110, 4'h0});
        end
    endtask

    task automatic test_idle_scan();
        for (int c = 0; c < 2 * FRAME; c++) begin
            step(1'b0, 1'b0, 16'h0);
            compared++;
            if ({pending, digit_idx, an, digit} !== model_out()) begin
                mismatched++;
                $display("FAIL idle_scan cyc %0d: got %b expected %b", c,
                         {pending, digit_idx, an, digit}, model_out());
            end
        end
    endtask

    task automatic test_double_load();
        while ((t % FRAME) != 2) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h1111);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h5678);
        for (int c = 0; c < 2 * FRAME; c++) begin
            step(1'b0, 1'b0, 16'h0);
            compared++;
            if ({pending, digit_idx, an, digit} !== model_out() || digit === 4'h1) begin
                mismatched++;
                $display("FAIL double_load cyc %0d: got %b expected %b", c,
                         {pending, digit_idx, an, digit}, model_out());
            end
        end
    endtask

    task automatic test_load_mid_frame();
        while ((t / DIV) % 4 != 1) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h1234);
        compared++;
        if (pending !== 1'b1) begin
            mismatched++;
            $display("FAIL load_pending: got %b expected 1", pending);
        end
        for (int c = 0; c < 2 * FRAME; c++) begin
            step(1'b0, 1'b0, 16'h0);
            compared++;
            if ({pending, digit_idx, an, digit} !== model_out()) begin
                mismatched++;
                $display("FAIL load_mid_frame cyc %0d: got %b expected %b", c,
                         {pending, digit_idx, an, digit}, model_out());
            end
        end
    endtask

    task automatic test_boundary_load();
        while ((t % FRAME) != FRAME - 1) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h9999);
        compared++;
        if ({pending, digit_idx, an, digit} !== {1'b0, 2'd0, 4'b1110, 4'h9}) begin
            mismatched++;
            $display("FAIL boundary_load: got %b expected %b", {pending, digit_idx, an, digit},
                     {1'b0, 2'd0, 4'b1110, 4'h9});
        end
    endtask

    task automatic test_reset_mid_frame();
        while ((t % FRAME) != 5) step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'habcd);
        step(1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 16'h4321);
        compared++;
        if ({pending, digit_idx, an, digit} !== {1'b0, 2'd0, 4'b1110, 4'h0}) begin
            mismatched++;
            $display("FAIL reset_mid_frame: got %b expected %b", {pending, digit_idx, an, digit},
                     {1'b0, 2'd0, 4'b1110, 4'h0});
        end
        for (int c = 0; c < FRAME + 2; c++) begin
            step(1'b0, 1'b0, 16'h0);
            compared++;
            if ({pending, digit_idx, an, digit} !== model_out()) begin
                mismatched++;
                $display("FAIL post_reset cyc %0d: got %b expected %b", c,
                         {pending, digit_idx, an, digit}, model_out());
            end
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_blanking();
        logic [15:0] vals [2];
        vals[0] = 16'h0042;
        vals[1] = 16'h0000;
        for (int v = 0; v < 2; v++) begin
            while ((t % FRAME) != FRAME - 1) step(1'b0, 1'b0, 16'h0);
            step(1'b0, 1'b1, vals[v]);
            for (int c = 0; c < FRAME; c++) begin
                compared++;
                if ({pending, digit_idx, an, digit} !== model_out()) begin
                    mismatched++;
                    $display("FAIL blanking val %h cyc %0d: got %b expected %b", vals[v], c,
                             {pending, digit_idx, an, digit}, model_out());
                end
                step(1'b0, 1'b0, 16'h0);
            end
        end
    endtask
`endif

    task automatic test_random();
        logic        r;
        logic        l;
        logic [15:0] dv;
        for (int c = 0; c < 2000; c++) begin
            r  = ($urandom_range(0, 299) == 0);
            l  = ($urandom_range(0, 7) == 0);
            dv = 16'($urandom);
            step(r, l, dv);
            compared++;
            if ({pending, digit_idx, an, digit} !== model_out()) begin
                mismatched++;
                $display("FAIL random cyc %0d: got %b expected %b", c,
                         {pending, digit_idx, an, digit}, model_out());
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        t          = 0;
        m_shadow   = 16'h0000;
        m_disp     = 16'h0000;
        m_pend     = 1'b0;
        rst        = 1'b1;
        load       = 1'b0;
        data_in    = 16'h0000;

        test_reset();
        test_idle_scan();
        test_double_load();
        test_load_mid_frame();
        test_boundary_load();
        test_reset_mid_frame();
`ifdef LEADING_ZERO_BLANK_EN
        test_blanking();
`endif
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
